// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle FP32 add/sub controller: one 24b barrel shifter for align,
// single adder, bit-serial left normalize, then pack into Result/flags.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   start              request, sampled only in IDLE
//   A, B               IEEE-754 single operands
//   busy               high whenever state != IDLE
//   done               one-cycle pulse; Result/flags valid from this cycle
//   Result             packed sum, held until the next done
//   Overflow           exponent saturated to infinity
//   Underflow          result flushed to zero
//   Invalid            exp==255 on an input
module fp_add_seq_ctrl #(
  parameter int NORM_MAX = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result,
  output logic        Overflow,
  output logic        Underflow,
  output logic        Invalid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  localparam logic [4:0] LP_NMAX = 5'(NORM_MAX);

  state_t      r_state;
  state_t      w_state_n;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sign;
  logic [8:0]  r_exp9;
  logic [23:0] r_mbig;
  logic [23:0] r_aligned;
  logic        r_effsub;
  logic [24:0] r_sum;
  logic [4:0]  r_iter;

  logic        w_in_inv;
  logic [23:0] w_a_m;
  logic [23:0] w_b_m;
  logic        w_a_big;
  logic [7:0]  w_big_exp;
  logic [7:0]  w_sml_exp;
  logic [23:0] w_big_m;
  logic [23:0] w_sml_m;
  logic        w_big_sign;
  logic [7:0]  w_diff;
  logic [4:0]  w_shamt;
  logic [23:0] w_s1;
  logic [23:0] w_s2;
  logic [23:0] w_s3;
  logic [23:0] w_s4;
  logic [23:0] w_s5;
  logic [24:0] w_sum25;
  logic [8:0]  w_exp_inc;
  logic        w_shift;

  logic        w_ld;
  logic [31:0] w_res_n;
  logic        w_ovf_n;
  logic        w_unf_n;
  logic        w_inv_n;

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  assign w_in_inv = (A[30:23] == 8'hFF) |
                    (B[30:23] == 8'hFF);

  // Denormals are flushed: a zero exponent zeroes the whole significand.
  assign w_a_m = (r_a[30:23] != 8'd0) ?
                 {1'b1, r_a[22:0]} : 24'd0;
  assign w_b_m = (r_b[30:23] != 8'd0) ?
                 {1'b1, r_b[22:0]} : 24'd0;

  // Magnitude compare on {exp,mant}; ties keep A as the big operand.
  assign w_a_big    = (r_a[30:0] >= r_b[30:0]);
  assign w_big_exp  = w_a_big ? r_a[30:23] : r_b[30:23];
  assign w_sml_exp  = w_a_big ? r_b[30:23] : r_a[30:23];
  assign w_big_m    = w_a_big ? w_a_m : w_b_m;
  assign w_sml_m    = w_a_big ? w_b_m : w_a_m;
  assign w_big_sign = w_a_big ? r_a[31] : r_b[31];

  assign w_diff  = w_big_exp - w_sml_exp;
  assign w_shamt = (w_diff > 8'd31) ? 5'd31 : w_diff[4:0];

  // Log-stage right shifter; amounts >= 24 fall out as zero.
  assign w_s1 = w_shamt[0] ? (w_sml_m >> 1)  : w_sml_m;
  assign w_s2 = w_shamt[1] ? (w_s1    >> 2)  : w_s1;
  assign w_s3 = w_shamt[2] ? (w_s2    >> 4)  : w_s2;
  assign w_s4 = w_shamt[3] ? (w_s3    >> 8)  : w_s3;
  assign w_s5 = w_shamt[4] ? (w_s4    >> 16) : w_s4;

  assign w_sum25 = r_effsub ?
                   ({1'b0, r_mbig} - {1'b0, r_aligned}) :
                   ({1'b0, r_mbig} + {1'b0, r_aligned});

  assign w_exp_inc = r_exp9 + 9'd1;
  assign w_shift   = ~r_sum[24] & ~r_sum[23];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_ld      = 1'b0;
    w_res_n   = Result;
    w_ovf_n   = 1'b0;
    w_unf_n   = 1'b0;
    w_inv_n   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_in_inv) begin
            w_state_n = S_DONE;
            w_ld      = 1'b1;
            w_res_n   = 32'h7FC0_0000;
            w_inv_n   = 1'b1;
          end else begin
            w_state_n = S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        w_state_n = S_ADD;
      end
      S_ADD: begin
        if (w_sum25 == 25'd0) begin
          w_state_n = S_DONE;
          w_ld      = 1'b1;
          w_res_n   = 32'h0000_0000;
        end else begin
          w_state_n = S_NORM;
        end
      end
      S_NORM: begin
        if (r_sum[24]) begin
          w_state_n = S_DONE;
          w_ld      = 1'b1;
          if (w_exp_inc == 9'd255) begin
            w_res_n = {r_sign, 8'hFF, 23'd0};
            w_ovf_n = 1'b1;
          end else begin
            w_res_n = {r_sign, w_exp_inc[7:0],
                       r_sum[23:1]};
          end
        end else if (r_sum[23]) begin
          w_state_n = S_DONE;
          w_ld      = 1'b1;
          w_res_n   = {r_sign, r_exp9[7:0],
                       r_sum[22:0]};
        end else if ((r_exp9 <= 9'd1) ||
                     (r_iter >= LP_NMAX)) begin
          w_state_n = S_DONE;
          w_ld      = 1'b1;
          w_res_n   = 32'h0000_0000;
          w_unf_n   = 1'b1;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_sign    <= 1'b0;
      r_exp9    <= 9'd0;
      r_mbig    <= 24'd0;
      r_aligned <= 24'd0;
      r_effsub  <= 1'b0;
      r_sum     <= 25'd0;
      r_iter    <= 5'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a <= A;
            r_b <= B;
          end
        end
        S_ALIGN: begin
          r_sign    <= w_big_sign;
          r_exp9    <= {1'b0, w_big_exp};
          r_mbig    <= w_big_m;
          r_aligned <= w_s5;
          r_effsub  <= r_a[31] ^ r_b[31];
          r_iter    <= 5'd0;
        end
        S_ADD: begin
          r_sum <= w_sum25;
        end
        S_NORM: begin
          if (w_shift) begin
            r_sum  <= {r_sum[23:0], 1'b0};
            r_exp9 <= r_exp9 - 9'd1;
            r_iter <= r_iter + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result and flags only move on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Result    <= 32'd0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Invalid   <= 1'b0;
    end else if (w_ld) begin
      Result    <= w_res_n;
      Overflow  <= w_ovf_n;
      Underflow <= w_unf_n;
      Invalid   <= w_inv_n;
    end
  end

endmodule
